adder_tree_window_accum: RTL and testbench

//  Downstream stage of the registered adder tree. Consumes the tree's per-cycle
//  sum stream, accumulates WINDOW consecutive sums and emits one window total
//  (plus mean) through a valid/ready output register. Backpressure stalls intake.

---
 rtl/adder_tree_window_accum_if.sv | 29 ++
 rtl/adder_tree_window_accum.sv | 88 ++++++++
 tb/tb_adder_tree_window_accum.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/adder_tree_window_accum_if.sv
// Stream bundle between the adder tree, the window accumulator and its consumer.
// The slave side is the accumulator; the master side drives samples and drains results.
interface adder_tree_window_accum_if #(
  parameter int IN_WIDTH = 16,
  parameter int WINDOW   = 16
);
  localparam int CNT_W     = $clog2(WINDOW) + 1;
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(WINDOW);

  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_ready;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]     out_count;
  logic [IN_WIDTH-1:0]  out_mean;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, out_mean
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_mean
  );
endinterface

// File: rtl/adder_tree_window_accum.sv
// Accumulates WINDOW consecutive tree sums (or a flushed partial window) and
// presents total, sample count and mean through a single-entry output register.
module adder_tree_window_accum #(
  parameter int IN_WIDTH = 16,
  parameter int WINDOW   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  adder_tree_window_accum_if.slave    bus
);
  localparam int SHIFT     = $clog2(WINDOW);
  localparam int CNT_W     = SHIFT + 1;
  localparam int OUT_WIDTH = IN_WIDTH + SHIFT;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t               state_reg;
  logic [OUT_WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 out_valid_reg;
  logic [OUT_WIDTH-1:0] out_data_reg;
  logic [CNT_W-1:0]     out_count_reg;
  logic [IN_WIDTH-1:0]  out_mean_reg;

  logic                 in_ready;
  logic                 accept;
  logic                 flush_ok;
  logic                 close;
  logic [OUT_WIDTH-1:0] sum_next;
  logic [CNT_W-1:0]     cnt_next;

  // Both intake and flush stall while a result is waiting and not being taken.
  assign in_ready = !(out_valid_reg && !bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign flush_ok = bus.flush && in_ready;

  always_comb begin
    sum_next = (state_reg == S_ACC) ? acc_reg : '0;
    cnt_next = (state_reg == S_ACC) ? cnt_reg : '0;
    if (accept) begin
      sum_next = sum_next + OUT_WIDTH'(bus.in_data);
      cnt_next = cnt_next + CNT_W'(1);
    end
    // A flush with nothing accumulated and no sample this cycle produces no result.
    close = (accept && (cnt_next == CNT_W'(WINDOW))) ||
            (flush_ok && (cnt_next != '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      out_mean_reg  <= '0;
    end else begin
      if (close) begin
        state_reg     <= S_IDLE;
        acc_reg       <= '0;
        cnt_reg       <= '0;
        out_valid_reg <= 1'b1;
        out_data_reg  <= sum_next;
        out_count_reg <= cnt_next;
        out_mean_reg  <= sum_next[OUT_WIDTH-1:SHIFT];
      end else begin
        if (accept) begin
          state_reg <= S_ACC;
          acc_reg   <= sum_next;
          cnt_reg   <= cnt_next;
        end
        if (bus.out_ready) begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_count = out_count_reg;
  assign bus.out_mean  = out_mean_reg;
endmodule

// File: tb/tb_adder_tree_window_accum.sv
// Directed bench: a behavioural model predicts handshakes and queues expected
// window results, which are compared whenever the DUT presents a result.
module tb_adder_tree_window_accum;
  localparam int IN_WIDTH = 16;
  localparam int WINDOW   = 16;

  typedef struct {
    logic [31:0] data;
    logic [31:0] count;
  } result_t;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  result_t     exp_q[$];
  logic [31:0] m_acc;
  logic [31:0] m_cnt;
  logic        m_ovalid;

  adder_tree_window_accum_if #(.IN_WIDTH(IN_WIDTH), .WINDOW(WINDOW)) bus ();

  adder_tree_window_accum #(.IN_WIDTH(IN_WIDTH), .WINDOW(WINDOW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // One clock: drive inputs, check handshake/result against the model, advance the model.
  task automatic step(input logic v, input logic [IN_WIDTH-1:0] d, input logic f,
                      input logic ordy);
    logic        exp_rdy;
    logic        acc_ok;
    logic        fl_ok;
    logic        close;
    logic [31:0] n_sum;
    logic [31:0] n_cnt;
    result_t     r;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.flush     = f;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !(m_ovalid && !ordy);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ovalid));
    if (m_ovalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(bus.out_valid), 32'd0);
      end else begin
        r = exp_q[0];
        chk("out_data", 32'(bus.out_data), r.data);
        chk("out_count", 32'(bus.out_count), r.count);
        if (r.count == WINDOW) chk("out_mean", 32'(bus.out_mean), r.data >> $clog2(WINDOW));
        if (ordy) void'(exp_q.pop_front());
      end
    end
    acc_ok = v && exp_rdy;
    fl_ok  = f && exp_rdy;
    n_sum  = m_acc + (acc_ok ? 32'(d) : 32'd0);
    n_cnt  = m_cnt + (acc_ok ? 32'd1 : 32'd0);
    close  = (acc_ok && n_cnt == WINDOW) || (fl_ok && n_cnt != 0);
    if (close) begin
      r.data  = n_sum;
      r.count = n_cnt;
      exp_q.push_back(r);
      m_acc = 0;
      m_cnt = 0;
    end else begin
      m_acc = n_sum;
      m_cnt = n_cnt;
    end
    m_ovalid = close ? 1'b1 : (ordy ? 1'b0 : m_ovalid);
    $display("step v=%0d d=%0d flush=%0d out_ready=%0d acc=%0d cnt=%0d", v, d, f, ordy, m_acc, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'd77;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_out_mean", 32'(bus.out_mean), 32'd0);
    rst_n    = 1'b1;
    m_acc    = 0;
    m_cnt    = 0;
    m_ovalid = 1'b0;
    exp_q.delete();
    $display("reset applied");
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    m_acc         = 0;
    m_cnt         = 0;
    m_ovalid      = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Full window of 1000s
    for (int i = 0; i < 16; i++) step(1'b1, 16'd1000, 1'b0, 1'b1);
    repeat (2) step(1'b0, 16'd0, 1'b0, 1'b1);

    // Maximum samples, no overflow
    for (int i = 0; i < 16; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    repeat (2) step(1'b0, 16'd0, 1'b0, 1'b1);

    // Backpressure: pending result holds, intake and flush stall, then resume
    for (int i = 0; i < 16; i++) step(1'b1, 16'(5 + i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'(100 + i), (i == 2), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 16'd3, 1'b0, 1'b1);
    repeat (2) step(1'b0, 16'd0, 1'b0, 1'b1);

    // Partial window flush, then flush while idle gives nothing
    step(1'b1, 16'd7, 1'b0, 1'b1);
    step(1'b1, 16'd8, 1'b0, 1'b1);
    step(1'b1, 16'd9, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b1, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 16'd0, 1'b0, 1'b1);

    // Flush with accept while idle: single-sample result
    step(1'b1, 16'd42, 1'b1, 1'b1);
    repeat (2) step(1'b0, 16'd0, 1'b0, 1'b1);

    // Flush together with the final sample: one full-window result
    for (int i = 0; i < 15; i++) step(1'b1, 16'd1, 1'b0, 1'b1);
    step(1'b1, 16'd1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 16'd0, 1'b0, 1'b1);

    // Reset mid-window discards the partial sum
    for (int i = 0; i < 5; i++) step(1'b1, 16'd9, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'd2, 1'b0, 1'b1);
    repeat (2) step(1'b0, 16'd0, 1'b0, 1'b1);

    // Back-to-back windows with no bubble
    for (int i = 0; i < 32; i++) step(1'b1, 16'(i * 311), 1'b0, 1'b1);
    repeat (3) step(1'b0, 16'd0, 1'b0, 1'b1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
